ex_muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage. It takes over integer multiply and divide work that the single-cycle path cannot finish in one cycle, iterating one bit per cycle. It drives the EX "over" handshake so the pipeline holds the instruction until the result is ready. It sits beside the ALU in EX, and its result joins the EX result mux ahead of the EX→MEM0 bus and the EX→ID forward path.

---
 rtl/ex_muldiv_seq_pkg.sv | 42 ++++
 rtl/ex_muldiv_seq_if.sv | 32 +++
 rtl/ex_muldiv_seq_muldiv_step.sv | 40 ++++
 rtl/ex_muldiv_seq.sv | 139 +++++++++++++
 tb/tb_ex_muldiv_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_seq_pkg
//  Description : Shared op codes, state encoding and op-class helpers for the
//                EX-stage multi-cycle multiply/divide sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_seq_pkg;

    localparam int MD_OP_W    = 3;
    localparam int MD_STATE_W = 2;

    typedef enum logic [MD_OP_W-1:0] {
        OP_MUL   = 3'd0,   // low word of product
        OP_MULH  = 3'd1,   // signed high word
        OP_MULHU = 3'd2,   // unsigned high word
        OP_DIV   = 3'd3,   // signed quotient
        OP_MOD   = 3'd4,   // signed remainder
        OP_DIVU  = 3'd5,   // unsigned quotient
        OP_MODU  = 3'd6,   // unsigned remainder
        OP_RSVD  = 3'd7    // reserved, behaves as MUL
    } md_op_e;

    typedef enum logic [MD_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Divide-class ops share the restoring-division datapath.
    function automatic logic op_is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_MOD) || (op == OP_DIVU) || (op == OP_MODU);
    endfunction

    // Ops whose operands are converted to magnitudes before iterating.
    // MUL is excluded: its low word is identical for signed and unsigned.
    function automatic logic op_is_signed(input md_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_seq_if
//  Description : EX-side handshake bundle for the mul/div sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_seq_if
    import ex_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic               valid_i;
    logic [MD_OP_W-1:0] op_i;
    logic [WIDTH-1:0]   opd1_i;
    logic [WIDTH-1:0]   opd2_i;
    logic               ready_i;
    logic               flush_i;
    logic               busy_o;
    logic               done_o;
    logic [WIDTH-1:0]   result_o;

    modport slave (
        input  valid_i, op_i, opd1_i, opd2_i, ready_i, flush_i,
        output busy_o, done_o, result_o
    );

    modport master (
        output valid_i, op_i, opd1_i, opd2_i, ready_i, flush_i,
        input  busy_o, done_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_seq_muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One iteration of the mul/div datapath. The 2*WIDTH
//                accumulator is {hi, lo}: for multiply {partial product,
//                multiplier}, for divide {remainder, quotient}.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic                 i_is_div,
    input  wire logic [2*WIDTH-1:0]   i_acc,
    input  wire logic [WIDTH-1:0]     i_b,
    output logic      [2*WIDTH-1:0]   o_acc
);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_shl;

    // Add-shift for multiply, shift/trial-subtract for restoring divide.
    always_comb begin
        w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_b} : '0);
        w_shl  = {i_acc[2*WIDTH-2:0], 1'b0};
        // The bit shifted out of the remainder is kept as a carry so that
        // divisors with the MSB set still compare correctly.
        w_diff = {i_acc[2*WIDTH-1], w_shl[2*WIDTH-1:WIDTH]} - {1'b0, i_b};
        o_acc  = {w_sum, i_acc[WIDTH-1:1]};
        if (i_is_div) begin
            if (!w_diff[WIDTH]) begin
                o_acc = {w_diff[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};
            end else begin
                o_acc = w_shl;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_seq
//  Description : Multi-cycle (one bit per cycle) multiply/divide sequencer
//                for EX. Holds the EX "over" handshake via done_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic      clk_i,
    input  wire logic      rst_i,
    ex_muldiv_seq_if.slave bus
);

    localparam int               c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    md_state_e            r_state;
    md_state_e            w_state_nxt;
    md_op_e               r_op;
    logic                 r_sign1;
    logic                 r_sign2;
    logic                 r_dz;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_b;

    logic                 w_accept;
    logic                 w_last;
    md_op_e               w_in_op;
    logic                 w_in_s1;
    logic                 w_in_s2;
    logic [WIDTH-1:0]     w_in_mag1;
    logic [WIDTH-1:0]     w_in_mag2;
    logic [2*WIDTH-1:0]   w_step_acc;
    logic [2*WIDTH-1:0]   w_acc_neg;
    logic [WIDTH-1:0]     w_lo_neg;
    logic [WIDTH-1:0]     w_hi_neg;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_result;

    assign w_accept = (r_state == ST_IDLE) & bus.valid_i & ~bus.flush_i;
    assign w_last   = (r_cnt == c_CNT_LAST);

    // Operand sign capture and magnitude conversion at accept time.
    always_comb begin
        w_in_op   = md_op_e'(bus.op_i);
        w_in_s1   = op_is_signed(w_in_op) & bus.opd1_i[WIDTH-1];
        w_in_s2   = op_is_signed(w_in_op) & bus.opd2_i[WIDTH-1];
        w_in_mag1 = w_in_s1 ? (~bus.opd1_i + 1'b1) : bus.opd1_i;
        w_in_mag2 = w_in_s2 ? (~bus.opd2_i + 1'b1) : bus.opd2_i;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (op_is_div(r_op)),
        .i_acc    (r_acc),
        .i_b      (r_b),
        .o_acc    (w_step_acc)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)      w_state_nxt = ST_DONE;
            ST_DONE: if (bus.ready_i) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush_i) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Operand latch on accept, one datapath iteration per CALC cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op    <= OP_MUL;
            r_sign1 <= 1'b0;
            r_sign2 <= 1'b0;
            r_dz    <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
        end else if (w_accept) begin
            r_op    <= w_in_op;
            r_sign1 <= w_in_s1;
            r_sign2 <= w_in_s2;
            r_dz    <= (bus.opd2_i == '0);
            r_cnt   <= '0;
            r_acc   <= {{WIDTH{1'b0}}, w_in_mag1};
            r_b     <= w_in_mag2;
        end else if ((r_state == ST_CALC) && !bus.flush_i) begin
            r_acc   <= w_step_acc;
            r_cnt   <= w_last ? '0 : r_cnt + c_CNT_W'(1);
        end
    end

    // Sign fix-up of the unsigned magnitude result, and result selection.
    always_comb begin
        w_acc_neg = ~r_acc + 1'b1;
        w_lo_neg  = ~r_acc[WIDTH-1:0] + 1'b1;
        w_hi_neg  = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
        // Divide by zero: quotient forced to all ones; the remainder already
        // equals the dividend magnitude, and the sign fix-up restores opd1.
        w_quo     = r_dz ? '1 : ((r_sign1 ^ r_sign2) ? w_lo_neg : r_acc[WIDTH-1:0]);
        w_rem     = r_sign1 ? w_hi_neg : r_acc[2*WIDTH-1:WIDTH];
        case (r_op)
            OP_MUL, OP_RSVD: w_result = r_acc[WIDTH-1:0];
            OP_MULH:         w_result = (r_sign1 ^ r_sign2) ? w_acc_neg[2*WIDTH-1:WIDTH]
                                                            : r_acc[2*WIDTH-1:WIDTH];
            OP_MULHU:        w_result = r_acc[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU: w_result = w_quo;
            OP_MOD, OP_MODU: w_result = w_rem;
            default:         w_result = r_acc[WIDTH-1:0];
        endcase
    end

    assign bus.busy_o   = (r_state != ST_IDLE);
    assign bus.done_o   = (r_state == ST_DONE);
    assign bus.result_o = (r_state == ST_DONE) ? w_result : '0;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_seq
//  Description : Self-checking bench for ex_muldiv_seq: directed vector
//                table, randomized ops against an arithmetic reference, and
//                hand-written handshake/flush/reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_seq;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 33;
    localparam int NVEC    = 16;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[NVEC];

    ex_muldiv_seq_if #(.WIDTH(WIDTH)) bus ();

    ex_muldiv_seq #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the op's definition.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     pr;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            3'd1: begin pr = sa * sb; r = pr[63:32]; end
            3'd2: begin pr = ua * ub; r = pr[63:32]; end
            3'd3: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin pr = sa / sb; r = pr[31:0]; end
            end
            3'd4: begin
                if (b == 0) r = a;
                else begin pr = sa % sb; r = pr[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin pr = ua / ub; r = pr[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else begin pr = ua % ub; r = pr[31:0]; end
            end
            default: begin pr = ua * ub; r = pr[31:0]; end
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Accept one op, scramble the inputs afterwards, wait (bounded) for done.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        bus.valid_i = 1'b1;
        bus.op_i    = op;
        bus.opd1_i  = a;
        bus.opd2_i  = b;
        tick();
        bus.valid_i = 1'b0;
        bus.op_i    = 3'($urandom);
        bus.opd1_i  = $urandom;
        bus.opd2_i  = $urandom;
        lat = 1;
        while (bus.done_o !== 1'b1 && lat < LATENCY + 8) begin
            tick();
            lat++;
        end
        res = bus.result_o;
    endtask

    task automatic release_op();
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        logic [31:0] exp;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat;
        logic        seen;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[2]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006};
        vecs[3]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[5]  = '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC};
        vecs[6]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[7]  = '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        vecs[8]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{3'd7, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[11] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[12] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
        vecs[13] = '{3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[14] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[15] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

        bus.valid_i = 1'b0;
        bus.op_i    = '0;
        bus.opd1_i  = '0;
        bus.opd2_i  = '0;
        bus.ready_i = 1'b0;
        bus.flush_i = 1'b0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_busy",   32'(bus.busy_o), 32'd0);
        check("reset_done",   32'(bus.done_o), 32'd0);
        check("reset_result", bus.result_o,    32'd0);

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LATENCY));
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            release_op();
            check($sformatf("vec%0d_release_done", i), 32'(bus.done_o), 32'd0);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 50; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, res, lat);
            check($sformatf("rnd%0d_op%0d_%h_%h", i, op, a, b), res, model(op, a, b));
            release_op();
        end

        // ready_i held low for 5 DONE cycles with valid_i held high
        bus.valid_i = 1'b1;
        bus.op_i    = 3'd2;
        bus.opd1_i  = 32'h0000_0007;
        bus.opd2_i  = 32'hFFFF_FFFD;
        tick();
        lat = 1;
        while (bus.done_o !== 1'b1 && lat < LATENCY + 8) begin
            tick();
            lat++;
        end
        check("hold_latency", 32'(lat), 32'(LATENCY));
        held = bus.result_o;
        check("hold_first_result", held, 32'h0000_0006);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold_done_%0d", k), 32'(bus.done_o), 32'd1);
            check($sformatf("hold_result_%0d", k), bus.result_o, 32'h0000_0006);
        end
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        check("no_restart_busy", 32'(bus.busy_o), 32'd0);
        check("no_restart_done", 32'(bus.done_o), 32'd0);
        tick();
        check("next_accept_busy", 32'(bus.busy_o), 32'd1);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush_after_accept_busy", 32'(bus.busy_o), 32'd0);

        // Flush in CALC cycle 10, then a fresh MUL 3 x 4
        bus.valid_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.opd1_i  = 32'd5;
        bus.opd2_i  = 32'd6;
        tick();
        bus.valid_i = 1'b0;
        repeat (9) tick();
        check("calc10_busy", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("flush_busy", 32'(bus.busy_o), 32'd0);
        check("flush_done", 32'(bus.done_o), 32'd0);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen = 1'b1;
        end
        check("flush_no_done", 32'(seen), 32'd0);
        run_op(3'd0, 32'd3, 32'd4, res, lat);
        check("post_flush_latency", 32'(lat), 32'(LATENCY));
        check("post_flush_result", res, 32'd12);
        release_op();

        // Reset pulsed while in DONE
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, res, lat);
        check("pre_reset_result", res, 32'hFFFF_FFFD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_done_busy",   32'(bus.busy_o), 32'd0);
        check("rst_done_done",   32'(bus.done_o), 32'd0);
        check("rst_done_result", bus.result_o,    32'd0);
        tick();
        check("rst_done_stays_idle", 32'(bus.busy_o), 32'd0);

        // Reset pulsed mid-CALC
        bus.valid_i = 1'b1;
        bus.op_i    = 3'd5;
        bus.opd1_i  = 32'd100;
        bus.opd2_i  = 32'd7;
        tick();
        bus.valid_i = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_calc_busy", 32'(bus.busy_o), 32'd0);

        // flush_i and valid_i together in IDLE: no accept
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = 3'd0;
        bus.opd1_i  = 32'd3;
        bus.opd2_i  = 32'd3;
        tick();
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_valid_busy", 32'(bus.busy_o), 32'd0);
        seen = 1'b0;
        repeat (LATENCY + 2) begin
            tick();
            if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen = 1'b1;
        end
        check("flush_valid_no_done", 32'(seen), 32'd0);

        // One more op after all the disturbances
        run_op(3'd6, 32'd100, 32'd7, res, lat);
        exp = model(3'd6, 32'd100, 32'd7);
        check("final_modu_result", res, exp);
        release_op();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
